patch_config_sequencer: RTL and testbench

Sequences the loading of one complete patch entry (CAM address, CAM mask, buffer offset and CAM write trigger) onto the patch config bus. It sits between the USB config decoder and the patch storage block, and shares the single config bus between raw host writes and its own generated writes. Host writes have absolute priority. The sequencer enforces a minimum spacing between CAM write triggers so that the 16-cycle CAM write always completes.

---
 rtl/patch_config_sequencer_if.sv | 29 ++
 rtl/patch_config_sequencer.sv | 132 +++++++++++++
 tb/tb_patch_config_sequencer.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/patch_config_sequencer_if.sv
// Config-bus bundle: host write port, patch-entry request handshake and the shared config-bus outputs.
interface patch_config_sequencer_if;
    logic [15:0] host_addr;
    logic [15:0] host_data;
    logic        host_strobe;
    logic        req_valid;
    logic        req_ready;
    logic [22:0] req_addr;
    logic [22:0] req_mask;
    logic [5:0]  req_index;
    logic [12:0] req_offset;
    logic [15:0] cfg_addr;
    logic [15:0] cfg_data;
    logic        cfg_strobe;
    logic        busy;
    logic        conflict;

    modport master (
        output host_addr, host_data, host_strobe,
        output req_valid, req_addr, req_mask, req_index, req_offset,
        input  req_ready, cfg_addr, cfg_data, cfg_strobe, busy, conflict
    );

    modport slave (
        input  host_addr, host_data, host_strobe,
        input  req_valid, req_addr, req_mask, req_index, req_offset,
        output req_ready, cfg_addr, cfg_data, cfg_strobe, busy, conflict
    );
endinterface

// File: rtl/patch_config_sequencer.sv
// Loads one CAM patch entry as six config-bus writes, yielding the bus to host writes,
// then idles CAM_WR_GAP cycles after the trigger so the CAM write can finish.
module patch_config_sequencer #(
    parameter int unsigned CAM_WR_GAP = 16
) (
    input logic                     mclk,
    input logic                     reset,
    patch_config_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, W_ALO, W_AHI, W_MLO, W_MHI, W_OFS, W_TRG, GAP
    } state_t;

    localparam logic [7:0] GAP_LOAD = 8'(CAM_WR_GAP);

    state_t      state, state_nx;
    logic [22:0] addr_q, mask_q;
    logic [5:0]  index_q;
    logic [12:0] offset_q;
    logic [7:0]  gap_cnt, gap_cnt_nx;
    logic [15:0] cfg_addr_q, cfg_data_q, cfg_addr_nx, cfg_data_nx;
    logic [15:0] seq_addr, seq_data;
    logic        cfg_strobe_q, cfg_strobe_nx;
    logic        conflict_q, conflict_nx;
    logic        idle, accept, in_write, host_cam;

    assign idle     = (state == IDLE);
    assign accept   = bus.req_valid && idle;
    assign host_cam = bus.host_strobe && (bus.host_addr >= 16'h7000) && (bus.host_addr <= 16'h7004);

    always_comb begin
        seq_addr = 16'h0000;
        seq_data = 16'h0000;
        in_write = 1'b1;
        case (state)
            W_ALO: begin seq_addr = 16'h7000; seq_data = addr_q[15:0]; end
            W_AHI: begin seq_addr = 16'h7001; seq_data = {9'b0, addr_q[22:16]}; end
            W_MLO: begin seq_addr = 16'h7002; seq_data = mask_q[15:0]; end
            W_MHI: begin seq_addr = 16'h7003; seq_data = {9'b0, mask_q[22:16]}; end
            W_OFS: begin seq_addr = 16'h7800 | {10'b0, index_q}; seq_data = {3'b0, offset_q}; end
            W_TRG: begin seq_addr = 16'h7004; seq_data = {10'b0, index_q}; end
            default: in_write = 1'b0;
        endcase
    end

    // Host strobe wins the bus; a write state simply stalls until the host lets go.
    always_comb begin
        state_nx      = state;
        gap_cnt_nx    = gap_cnt;
        cfg_addr_nx   = cfg_addr_q;
        cfg_data_nx   = cfg_data_q;
        cfg_strobe_nx = 1'b0;
        conflict_nx   = conflict_q;

        if (bus.host_strobe) begin
            cfg_addr_nx   = bus.host_addr;
            cfg_data_nx   = bus.host_data;
            cfg_strobe_nx = 1'b1;
        end else if (in_write) begin
            cfg_addr_nx   = seq_addr;
            cfg_data_nx   = seq_data;
            cfg_strobe_nx = 1'b1;
        end

        case (state)
            IDLE:  if (accept) state_nx = W_ALO;
            W_ALO: if (!bus.host_strobe) state_nx = W_AHI;
            W_AHI: if (!bus.host_strobe) state_nx = W_MLO;
            W_MLO: if (!bus.host_strobe) state_nx = W_MHI;
            W_MHI: if (!bus.host_strobe) state_nx = W_OFS;
            W_OFS: if (!bus.host_strobe) state_nx = W_TRG;
            W_TRG: if (!bus.host_strobe) begin
                gap_cnt_nx = GAP_LOAD;
                state_nx   = (GAP_LOAD == 8'd0) ? IDLE : GAP;
            end
            GAP: begin
                // Counts regardless of host traffic; the last count returns to IDLE.
                if (gap_cnt <= 8'd1) begin
                    gap_cnt_nx = 8'd0;
                    state_nx   = IDLE;
                end else begin
                    gap_cnt_nx = gap_cnt - 8'd1;
                end
            end
            default: state_nx = IDLE;
        endcase

        if (host_cam && !idle)
            conflict_nx = 1'b1;
        else if (accept)
            conflict_nx = 1'b0;
    end

    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            gap_cnt      <= 8'd0;
            cfg_addr_q   <= 16'h0000;
            cfg_data_q   <= 16'h0000;
            cfg_strobe_q <= 1'b0;
            conflict_q   <= 1'b0;
        end else begin
            state        <= state_nx;
            gap_cnt      <= gap_cnt_nx;
            cfg_addr_q   <= cfg_addr_nx;
            cfg_data_q   <= cfg_data_nx;
            cfg_strobe_q <= cfg_strobe_nx;
            conflict_q   <= conflict_nx;
        end
    end

    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            addr_q   <= 23'd0;
            mask_q   <= 23'd0;
            index_q  <= 6'd0;
            offset_q <= 13'd0;
        end else if (accept) begin
            addr_q   <= bus.req_addr;
            mask_q   <= bus.req_mask;
            index_q  <= bus.req_index;
            offset_q <= bus.req_offset;
        end
    end

    assign bus.req_ready  = idle;
    assign bus.busy       = !idle;
    assign bus.cfg_addr   = cfg_addr_q;
    assign bus.cfg_data   = cfg_data_q;
    assign bus.cfg_strobe = cfg_strobe_q;
    assign bus.conflict   = conflict_q;
endmodule

// File: tb/tb_patch_config_sequencer.sv
// Drives two sequencers (gap 16 and gap 0) with identical stimulus; a queue-based reference
// model predicts every config write and its edge, and a monitor checks them as they appear.
module tb_patch_config_sequencer;
    localparam int GAP0 = 16;
    localparam int GAP1 = 0;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] d;
        int          at;
    } wr_t;

    logic mclk  = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    bit   checking = 1'b0;
    bit   in_reset = 1'b0;

    patch_config_sequencer_if b0();
    patch_config_sequencer_if b1();

    patch_config_sequencer #(.CAM_WR_GAP(GAP0)) dut0 (.mclk(mclk), .reset(reset), .bus(b0));
    patch_config_sequencer #(.CAM_WR_GAP(GAP1)) dut1 (.mclk(mclk), .reset(reset), .bus(b1));

    always #5 mclk = ~mclk;
    always @(posedge mclk) cyc <= cyc + 1;

    // Reference model: pending writes of the current entry, and the edge after which it is free.
    wr_t         wq0[$];
    wr_t         wq1[$];
    logic [15:0] m_a [2][6];
    logic [15:0] m_d [2][6];
    int          m_pos [2];
    int          m_free [2];
    bit          m_acc [2];
    bit          exp_ready [2];
    bit          exp_conf [2];

    function automatic int gap_of(input int k);
        return (k == 0) ? GAP0 : GAP1;
    endfunction

    function automatic int wsize(input int k);
        return (k == 0) ? wq0.size() : wq1.size();
    endfunction

    function automatic int peek_at(input int k);
        return (k == 0) ? wq0[0].at : wq1[0].at;
    endfunction

    task automatic push_w(input int k, input wr_t w);
        if (k == 0) wq0.push_back(w); else wq1.push_back(w);
    endtask

    task automatic pop_w(input int k, output wr_t w);
        if (k == 0) w = wq0.pop_front(); else w = wq1.pop_front();
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pos[k] = 6; m_free[k] = 0; m_acc[k] = 1'b0;
            exp_ready[k] = 1'b1; exp_conf[k] = 1'b0;
        end
        wq0.delete();
        wq1.delete();
    endtask

    task automatic chk(input int k, input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d edge %0d: got 0x%0h, expected 0x%0h", nm, k, cyc, act, exp);
        end
    endtask

    task automatic model_step(input int k, input bit hs, input logic [15:0] ha, input logic [15:0] hd,
                              input bit rv, input logic [22:0] ra, input logic [22:0] rm,
                              input logic [5:0] ri, input logic [12:0] ro, input int at);
        bit  busy_before, acc;
        wr_t w;
        busy_before = (m_pos[k] < 6) || (at - 1 < m_free[k]);
        acc = rv && !busy_before;
        if (hs && ha >= 16'h7000 && ha <= 16'h7004 && busy_before) exp_conf[k] = 1'b1;
        else if (acc) exp_conf[k] = 1'b0;
        if (hs) begin
            w.a = ha; w.d = hd; w.at = at;
            push_w(k, w);
        end else if (m_pos[k] < 6) begin
            w.a = m_a[k][m_pos[k]]; w.d = m_d[k][m_pos[k]]; w.at = at;
            push_w(k, w);
            m_pos[k]++;
            if (m_pos[k] == 6) m_free[k] = at + gap_of(k);
        end
        if (acc) begin
            m_a[k][0] = 16'h7000;               m_d[k][0] = ra[15:0];
            m_a[k][1] = 16'h7001;               m_d[k][1] = {9'b0, ra[22:16]};
            m_a[k][2] = 16'h7002;               m_d[k][2] = rm[15:0];
            m_a[k][3] = 16'h7003;               m_d[k][3] = {9'b0, rm[22:16]};
            m_a[k][4] = 16'h7800 | {10'b0, ri}; m_d[k][4] = {3'b0, ro};
            m_a[k][5] = 16'h7004;               m_d[k][5] = {10'b0, ri};
            m_pos[k] = 0;
        end
        m_acc[k] = acc;
        exp_ready[k] = !((m_pos[k] < 6) || (at < m_free[k]));
    endtask

    task automatic step(input bit hs, input logic [15:0] ha, input logic [15:0] hd, input bit rv,
                        input logic [22:0] ra, input logic [22:0] rm, input logic [5:0] ri,
                        input logic [12:0] ro);
        @(negedge mclk);
        b0.host_strobe = hs; b0.host_addr = ha; b0.host_data = hd;
        b0.req_valid = rv; b0.req_addr = ra; b0.req_mask = rm; b0.req_index = ri; b0.req_offset = ro;
        b1.host_strobe = hs; b1.host_addr = ha; b1.host_data = hd;
        b1.req_valid = rv; b1.req_addr = ra; b1.req_mask = rm; b1.req_index = ri; b1.req_offset = ro;
        for (int k = 0; k < 2; k++) model_step(k, hs, ha, hd, rv, ra, rm, ri, ro, cyc + 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0, 16'h0, 1'b0, 23'h0, 23'h0, 6'h0, 13'h0);
    endtask

    task automatic host(input logic [15:0] ha, input logic [15:0] hd);
        step(1'b1, ha, hd, 1'b0, 23'h0, 23'h0, 6'h0, 13'h0);
    endtask

    task automatic req(input logic [22:0] ra, input logic [22:0] rm, input logic [5:0] ri, input logic [12:0] ro);
        step(1'b0, 16'h0, 16'h0, 1'b1, ra, rm, ri, ro);
    endtask

    task automatic check_inst(input int k, input logic st, input logic [15:0] a, input logic [15:0] d,
                              input logic rdy, input logic bsy, input logic cf);
        wr_t w;
        chk(k, "req_ready", 32'(rdy), 32'(exp_ready[k]));
        chk(k, "busy", 32'(bsy), 32'(!exp_ready[k]));
        chk(k, "conflict", 32'(cf), 32'(exp_conf[k]));
        if (st) begin
            if (wsize(k) == 0) begin
                chk(k, "spurious_strobe", 32'(st), 32'd0);
            end else begin
                pop_w(k, w);
                chk(k, "cfg_addr", 32'(a), 32'(w.a));
                chk(k, "cfg_data", 32'(d), 32'(w.d));
                chk(k, "write_edge", 32'(cyc), 32'(w.at));
            end
        end else if (wsize(k) > 0 && peek_at(k) <= cyc) begin
            pop_w(k, w);
            chk(k, "missing_strobe", 32'(st), 32'd1);
        end
    endtask

    initial begin
        forever begin
            @(posedge mclk);
            #1;
            if (checking && !in_reset) begin
                check_inst(0, b0.cfg_strobe, b0.cfg_addr, b0.cfg_data, b0.req_ready, b0.busy, b0.conflict);
                check_inst(1, b1.cfg_strobe, b1.cfg_addr, b1.cfg_data, b1.req_ready, b1.busy, b1.conflict);
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk(0, {tag, "_strobe"}, 32'(b0.cfg_strobe), 32'd0);
        chk(0, {tag, "_addr"}, 32'(b0.cfg_addr), 32'd0);
        chk(0, {tag, "_data"}, 32'(b0.cfg_data), 32'd0);
        chk(0, {tag, "_ready"}, 32'(b0.req_ready), 32'd1);
        chk(0, {tag, "_conflict"}, 32'(b0.conflict), 32'd0);
        chk(1, {tag, "_strobe"}, 32'(b1.cfg_strobe), 32'd0);
        chk(1, {tag, "_ready"}, 32'(b1.req_ready), 32'd1);
    endtask

    task automatic random_phase(input int n);
        logic [15:0] ha;
        for (int i = 0; i < n; i++) begin
            case ($urandom_range(0, 3))
                0: ha = 16'h7000 + 16'($urandom_range(0, 4));
                1: ha = 16'h7800 | 16'($urandom_range(0, 63));
                2: ha = 16'h8000 | 16'($urandom_range(0, 16'h7fff));
                default: ha = 16'($urandom);
            endcase
            step(($urandom_range(0, 3) == 0), ha, 16'($urandom), ($urandom_range(0, 2) == 0),
                 23'($urandom), 23'($urandom), 6'($urandom), 13'($urandom));
        end
    endtask

    initial begin
        model_reset();
        b0.host_strobe = 0; b0.host_addr = 0; b0.host_data = 0; b0.req_valid = 0;
        b0.req_addr = 0; b0.req_mask = 0; b0.req_index = 0; b0.req_offset = 0;
        b1.host_strobe = 0; b1.host_addr = 0; b1.host_data = 0; b1.req_valid = 0;
        b1.req_addr = 0; b1.req_mask = 0; b1.req_index = 0; b1.req_offset = 0;
        #1;
        check_reset_outputs("reset");
        repeat (3) @(negedge mclk);
        reset = 1'b0;
        checking = 1'b1;

        // Uncontended entry.
        req(23'h5A1234, 23'h00000F, 6'd5, 13'h0123);
        idle(30);
        // Host traffic outside the CAM window stalls the sequence.
        req(23'h5A1234, 23'h00000F, 6'd5, 13'h0123);
        idle(2);
        host(16'h8010, 16'hA001); host(16'h8010, 16'hA002); host(16'h8010, 16'hA003);
        idle(30);
        // Host write into the CAM staging registers mid-sequence.
        req(23'h5A1234, 23'h00000F, 6'd5, 13'h0123);
        idle(2);
        host(16'h7002, 16'hBEEF);
        idle(30);
        // req_valid held across two entries.
        for (int n = 0; n < 40; n++) begin
            req(23'h012345, 23'h000003, 6'd1, 13'h0011);
            if (m_acc[0]) break;
        end
        for (int n = 0; n < 40; n++) begin
            req(23'h06789A, 23'h000300, 6'd2, 13'h0022);
            if (m_acc[0]) break;
        end
        idle(40);

        random_phase(1500);
        idle(40);

        // Reset while the gap-16 instance sits in W_MHI.
        req(23'h7FFFFF, 23'h7F0000, 6'd63, 13'h1FFF);
        idle(3);
        @(negedge mclk);
        in_reset = 1'b1;
        reset = 1'b1;
        #1;
        check_reset_outputs("midreset");
        model_reset();
        @(negedge mclk);
        reset = 1'b0;
        in_reset = 1'b0;
        req(23'h2AAAAA, 23'h155555, 6'd9, 13'h0ABC);
        idle(30);

        random_phase(1000);
        idle(40);
        for (int k = 0; k < 2; k++) chk(k, "writes_outstanding", 32'(wsize(k)), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
